rr_grant_sched: RTL and testbench
=================================

// Module: rr_grant_sched
// PURPOSE
//  Round-robin scheduler sharing one 2-bit-indexed resource (e.g. a case-decoded
//  lookup unit) among 4 requesters. Picks one owner, holds the grant until the
//  owner releases it, then rotates priority. Sits between client ports and the
//  shared datapath; gnt_idx drives the datapath's select input directly.
// PARAMETERS
//  MAX_HOLD  8  max cycles a grant may be held (used only with ARB_TIMEOUT_EN); >=2
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  req        in   4  per-requester request, level
//  done       in   1  owner finished; valid only while gnt_valid=1
//  res_ready  in   1  shared resource can accept a new owner
//  gnt        out  4  one-hot grant, all-zero when idle
//  gnt_idx    out  2  encoded owner index; 2'b00 when idle
//  gnt_valid  out  1  a grant is active
//  timeout    out  1  1-cycle pulse: grant forcibly revoked
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: gnt=0, gnt_idx=2'b00, gnt_valid=0, timeout=0, state=IDLE,
//   last-owner pointer ptr=2'b11 (so requester 0 has top priority first).
//  States: IDLE -> HOLD -> IDLE. Encoded 1 bit; no other states.
//  IDLE: if res_ready && |req: winner = first set req scanning ptr+1, ptr+2,
//   ptr+3, ptr (mod 4, 2'b11 wraps to 2'b00). Registered: gnt/gnt_idx/gnt_valid
//   assert on the next edge (latency 1 cycle from req to gnt). Go HOLD.
//   If res_ready=0 or req=0: stay IDLE, outputs stay cleared.
//  HOLD: outputs stable. Release when done=1 OR req[gnt_idx]=0.
//   On release edge: ptr<=gnt_idx, gnt/gnt_valid clear, go IDLE.
//   One mandatory idle cycle between grants (no back-to-back re-grant).
//  Simultaneous: done with owner still requesting -> release anyway; owner
//   rotated to lowest priority. done while IDLE is ignored. req changes of
//   non-owners in HOLD are ignored.
//  Reset mid-HOLD: grant drops immediately (async), ptr returns to 2'b11.
//  Next-state/winner logic: single always_comb; every variable (incl. temporaries)
//   assigned default values at top, so no path leaves a variable unassigned;
//   block must pass the parser's combinational checks. Priority scan written as
//   a full case on ptr with default branch.
//  Invariants: gnt one-hot or zero; gnt_valid == |gnt; gnt[gnt_idx]==gnt_valid.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: hold counter (clog2(MAX_HOLD) bits) clears on entering
//   HOLD, increments each HOLD cycle; when it reaches MAX_HOLD-1 without release,
//   grant is revoked as a normal release (ptr<=gnt_idx, go IDLE) and timeout
//   pulses high that same cycle. done on the terminal cycle wins: no timeout.
//  ARB_TIMEOUT_EN undefined: no counter; HOLD lasts until release; timeout tied 0.
// TESTING
//  Reset, req=4'b1111, res_ready=1 -> next cycle gnt=4'b0001, gnt_idx=0.
//  Keep req=4'b1111, pulse done each grant -> owners 0,1,2,3,0 with 1 idle
//   cycle between grants (wrap 3->0 checked).
//  res_ready=0, req=4'b0100 -> no grant; raise res_ready -> gnt=4'b0100 next cycle.
//  Owner 2 drops req while in HOLD -> release next edge, gnt=0; ptr=2 so
//   req=4'b1100 then grants 3.
//  Assert rst_n=0 mid-HOLD (owner 1) -> gnt=0 asynchronously; after release,
//   req=4'b0011 -> grants 0.
//  ARB_TIMEOUT_EN, MAX_HOLD=4, owner 0 never done -> timeout=1 on 4th HOLD
//   cycle, gnt clears; done on that cycle instead -> timeout stays 0.

Source files
------------

// File: rtl/rr_grant_sched.sv
// rr_grant_sched: four-way round-robin grant scheduler for one shared resource.
// A winner is picked in IDLE, holds the grant in HOLD until it signals done or
// drops its request, then becomes lowest priority for the next pick.
// Optional feature macro: ARB_TIMEOUT_EN -- revokes a grant held for MAX_HOLD
// cycles and pulses timeout on the cycle of revocation.
module rr_grant_sched #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  input  logic       res_ready,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // A hold limit below 2 leaves no room for a grant to be seen before revocation.
  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("rr_grant_sched: MAX_HOLD must be >= 2");
  end

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;        // last owner; lowest priority in the next pick
  logic [1:0] owner, owner_nxt;    // current owner, 2'b00 while idle
  logic [1:0] o1, o2, o3, o4;      // scan order derived from ptr
  logic [1:0] win;
  logic       win_vld;
  logic       rel;                 // normal release by the owner
  logic       tmo;                 // forced release by the hold limit

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD);
  logic [CW-1:0] cnt, cnt_nxt;

  // Hold-cycle counter; restarts every time a grant is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end
`endif

  // State, pointer and owner registers; reset drops any live grant at once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'b11;
      owner <= 2'b00;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  // Priority scan, winner selection and next-state decision.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    o1        = 2'd0;
    o2        = 2'd1;
    o3        = 2'd2;
    o4        = 2'd3;
    win       = 2'b00;
    win_vld   = 1'b0;
    rel       = 1'b0;
    tmo       = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_nxt   = '0;
`endif

    // Scan starts just after the last owner and ends on it.
    case (ptr)
      2'b00:   begin o1 = 2'd1; o2 = 2'd2; o3 = 2'd3; o4 = 2'd0; end
      2'b01:   begin o1 = 2'd2; o2 = 2'd3; o3 = 2'd0; o4 = 2'd1; end
      2'b10:   begin o1 = 2'd3; o2 = 2'd0; o3 = 2'd1; o4 = 2'd2; end
      2'b11:   begin o1 = 2'd0; o2 = 2'd1; o3 = 2'd2; o4 = 2'd3; end
      default: begin o1 = 2'd0; o2 = 2'd1; o3 = 2'd2; o4 = 2'd3; end
    endcase

    if      (req[o1]) begin win = o1; win_vld = 1'b1; end
    else if (req[o2]) begin win = o2; win_vld = 1'b1; end
    else if (req[o3]) begin win = o3; win_vld = 1'b1; end
    else if (req[o4]) begin win = o4; win_vld = 1'b1; end

    case (state)
      IDLE: begin
        if (res_ready && win_vld) begin
          owner_nxt = win;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        rel = done || !req[owner];
`ifdef ARB_TIMEOUT_EN
        cnt_nxt = cnt + 1'b1;
        tmo     = !rel && (cnt == CW'(MAX_HOLD - 1));
`endif
        if (rel || tmo) begin
          ptr_nxt   = owner;
          owner_nxt = 2'b00;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_valid = (state == HOLD);
  assign gnt       = gnt_valid ? (4'b0001 << owner) : 4'b0000;
  assign gnt_idx   = owner;
  assign timeout   = tmo;

endmodule

// File: tb/tb_rr_grant_sched.sv
// Self-checking bench for rr_grant_sched: expected owners are queued when the
// stimulus is driven and popped when the grant appears.
module tb_rr_grant_sched;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       res_ready;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;
  int sb[$];

  rr_grant_sched #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .res_ready (res_ready),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the next expected owner; an empty scoreboard yields -1 (never matches).
  task automatic pop_exp(output int e);
    if (sb.size() == 0) e = -1;
    else                e = sb.pop_front();
  endtask

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = 4'b0000;
    if (i >= 0 && i < 4) v[i] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0000; done = 1'b0; res_ready = 1'b0;
    #12;
    total++;
    if (gnt !== 4'b0000 || gnt_idx !== 2'b00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: gnt=%b idx=%0d valid=%b timeout=%b want 0000/0/0/0",
               gnt, gnt_idx, gnt_valid, timeout);
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_first_grant();
    int e;
    req = 4'b1111; res_ready = 1'b1;
    sb.push_back(0);
    tick();
    pop_exp(e);
    total++;
    if (gnt !== onehot(e) || gnt_idx !== 2'(e) || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_grant: gnt=%b idx=%0d valid=%b want %b/%0d/1", gnt, gnt_idx, gnt_valid, onehot(e), e);
    end
  endtask

  task automatic test_rotation();
    int order[4] = '{1, 2, 3, 0};
    int e;
    foreach (order[k]) begin
      done = 1'b1;
      tick();
      done = 1'b0;
      total++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
        bad++;
        $display("FAIL rotation_idle_%0d: gnt=%b valid=%b want 0000/0", k, gnt, gnt_valid);
      end
      sb.push_back(order[k]);
      tick();
      pop_exp(e);
      total++;
      if (gnt !== onehot(e) || gnt_idx !== 2'(e) || gnt_valid !== 1'b1) begin
        bad++;
        $display("FAIL rotation_grant_%0d: gnt=%b idx=%0d want %b/%0d", k, gnt, gnt_idx, onehot(e), e);
      end
    end
    done = 1'b1; tick(); done = 1'b0; req = 4'b0000; tick();
  endtask

  task automatic test_res_ready();
    int e;
    res_ready = 1'b0; req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
        bad++;
        $display("FAIL not_ready_%0d: gnt=%b valid=%b want 0000/0", i, gnt, gnt_valid);
      end
    end
    res_ready = 1'b1;
    sb.push_back(2);
    tick();
    pop_exp(e);
    total++;
    if (gnt !== onehot(e) || gnt_idx !== 2'(e) || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL ready_grant: gnt=%b idx=%0d want %b/%0d", gnt, gnt_idx, onehot(e), e);
    end
  endtask

  task automatic test_owner_drop();
    int e;
    req = 4'b0000;
    tick();
    total++;
    if (gnt !== 4'b0000 || gnt_idx !== 2'b00 || gnt_valid !== 1'b0) begin
      bad++;
      $display("FAIL owner_drop_release: gnt=%b idx=%0d valid=%b want 0000/0/0", gnt, gnt_idx, gnt_valid);
    end
    req = 4'b1100;
    sb.push_back(3);
    tick();
    pop_exp(e);
    total++;
    if (gnt !== onehot(e) || gnt_idx !== 2'(e) || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL after_drop_grant: gnt=%b idx=%0d want %b/%0d", gnt, gnt_idx, onehot(e), e);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_hold();
    int e;
    req = 4'b0010;
    sb.push_back(1);
    tick();
    pop_exp(e);
    total++;
    if (gnt !== onehot(e) || gnt_idx !== 2'(e)) begin
      bad++;
      $display("FAIL pre_reset_grant: gnt=%b idx=%0d want %b/%0d", gnt, gnt_idx, onehot(e), e);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'b00) begin
      bad++;
      $display("FAIL async_reset_drop: gnt=%b valid=%b idx=%0d want 0000/0/0", gnt, gnt_valid, gnt_idx);
    end
    #1 rst_n = 1'b1;
    req = 4'b0011;
    sb.push_back(0);
    tick();
    pop_exp(e);
    total++;
    if (gnt !== onehot(e) || gnt_idx !== 2'(e) || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_grant: gnt=%b idx=%0d want %b/%0d", gnt, gnt_idx, onehot(e), e);
    end
  endtask

  task automatic test_hold_rules();
    logic [3:0] pats[2] = '{4'b1011, 4'b0111};
    int e;
    foreach (pats[k]) begin
      req = pats[k];
      tick();
      total++;
      if (gnt !== 4'b0001 || gnt_valid !== 1'b1) begin
        bad++;
        $display("FAIL hold_stable_%0d: gnt=%b valid=%b want 0001/1", k, gnt, gnt_valid);
      end
    end
    req = 4'b0011; done = 1'b1;
    tick();
    done = 1'b0;
    total++;
    if (gnt !== 4'b0000) begin
      bad++;
      $display("FAIL done_still_req_release: gnt=%b want 0000", gnt);
    end
    sb.push_back(1);
    tick();
    pop_exp(e);
    total++;
    if (gnt !== onehot(e) || gnt_idx !== 2'(e)) begin
      bad++;
      $display("FAIL rotated_after_done: gnt=%b idx=%0d want %b/%0d", gnt, gnt_idx, onehot(e), e);
    end
    req = 4'b0000;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    total++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
      bad++;
      $display("FAIL done_in_idle: gnt=%b valid=%b want 0000/0", gnt, gnt_valid);
    end
  endtask

  task automatic test_timeout();
    int e;
    req = 4'b0001;
    sb.push_back(0);
    tick();
    pop_exp(e);
    total++;
    if (gnt !== onehot(e) || timeout !== 1'b0) begin
      bad++;
      $display("FAIL hold_start: gnt=%b timeout=%b want %b/0", gnt, timeout, onehot(e));
    end
`ifdef ARB_TIMEOUT_EN
    tick(); tick(); tick();
    total++;
    if (timeout !== 1'b1 || gnt !== 4'b0001) begin
      bad++;
      $display("FAIL timeout_pulse: timeout=%b gnt=%b want 1/0001", timeout, gnt);
    end
    tick();
    total++;
    if (timeout !== 1'b0 || gnt !== 4'b0000) begin
      bad++;
      $display("FAIL timeout_release: timeout=%b gnt=%b want 0/0000", timeout, gnt);
    end
    sb.push_back(0);
    tick();
    pop_exp(e);
    total++;
    if (gnt !== onehot(e)) begin
      bad++;
      $display("FAIL regrant_after_timeout: gnt=%b want %b", gnt, onehot(e));
    end
    tick(); tick(); tick();
    done = 1'b1;
    #1;
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL done_beats_timeout: timeout=%b want 0", timeout);
    end
    tick();
    done = 1'b0;
    total++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL done_terminal_release: gnt=%b timeout=%b want 0000/0", gnt, timeout);
    end
`else
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (gnt !== 4'b0001 || timeout !== 1'b0) begin
        bad++;
        $display("FAIL long_hold_%0d: gnt=%b timeout=%b want 0001/0", i, gnt, timeout);
      end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    total++;
    if (gnt !== 4'b0000) begin
      bad++;
      $display("FAIL long_hold_release: gnt=%b want 0000", gnt);
    end
`endif
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_rotation();
    test_res_ready();
    test_owner_drop();
    test_reset_mid_hold();
    test_hold_rules();
    test_timeout();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
